window_multiplier: RTL and testbench

- Sits directly downstream of the overlapped-window FIFO address manager and its sample RAM.
- Pulls samples by driving `dequeue`, pairs each returned RAM word with the window-function coefficient indexed by `window_addr`, and multiplies with rounding.
- Streams windowed samples to the FFT stage over a valid/ready interface with a per-window `m_last`.
- Uses credit-based flow control plus an internal output FIFO, so samples are never dropped under backpressure.

---
 rtl/window_multiplier.sv | 215 +++++++++++++++++++++
 tb/tb_window_multiplier.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_multiplier.sv
// Windows each upstream sample by its coefficient with round-half-up and saturation.
// Latency: read in cycle N -> m_valid in cycle N+3 when the output FIFO is empty; 1 sample/cycle sustained.
// Backpressure: credits cover S1/S2 plus the FIFO, so dequeue drops before anything would be lost.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   dequeue / read        request to / grant from the address manager
//   window_addr           window index of the sample read this cycle
//   ram_data, coef_data   sample and coefficient, both valid the cycle after read
//   coef_addr             coefficient ROM address (combinational copy of window_addr)
//   m_data/m_valid/m_ready/m_last  windowed sample stream to the FFT stage
//   overflow              sticky protocol-violation flag (read with no free credit)

// Small first-word-fall-through FIFO used for the output queue.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module wm_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   L_CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] L_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_pop_vld = (r_count != '0);
    assign o_full    = (r_count == L_DEPTH);
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_pop  = i_pop_rdy && o_pop_vld;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_push = i_push_vld && (!o_full || w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module window_multiplier #(
    parameter int ADDRWIDTH  = 12,
    parameter int DATAWIDTH  = 16,
    parameter int COEFWIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 dequeue,
    input  logic                 read,
    input  logic [ADDRWIDTH-1:0] window_addr,
    input  logic [DATAWIDTH-1:0] ram_data,
    output logic [ADDRWIDTH-1:0] coef_addr,
    input  logic [COEFWIDTH-1:0] coef_data,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 overflow
);
    // Product of a signed sample and a zero-extended coefficient.
    localparam int PW = DATAWIDTH + COEFWIDTH + 1;
    // One guard bit so adding the rounding constant cannot wrap.
    localparam int RW = PW + 1;
    // Width of the rounded quotient before saturation.
    localparam int QW = RW - COEFWIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] L_FULL     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] L_CRED_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] L_HALF     = {{(RW-COEFWIDTH){1'b0}}, 1'b1, {(COEFWIDTH-1){1'b0}}};
    localparam logic signed [QW-1:0] L_MAX = {{(QW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] L_MIN = {{(QW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    // Pipeline state
    logic                 r_v1;
    logic                 r_last1;
    logic                 r_v2;
    logic                 r_last2;
    logic signed [PW-1:0] r_p2;
    logic [CW-1:0]        r_credits;
    logic                 r_overflow;

    logic signed [PW-1:0]  w_ram_ext;
    logic signed [PW-1:0]  w_coef_ext;
    logic signed [PW-1:0]  w_prod;
    logic signed [RW-1:0]  w_rnd_sum;
    logic signed [QW-1:0]  w_q;
    logic [DATAWIDTH-1:0]  w_sat;
    logic                  w_hs;
    logic                  w_violation;
    logic                  w_inc;
    logic                  w_fifo_vld;
    logic                  w_fifo_full;
    logic [DATAWIDTH:0]    w_fifo_head;

    // S0: coefficient lookup runs in parallel with the RAM read.
    assign coef_addr = window_addr;

    // S1: full-precision product; it always fits in PW bits.
    assign w_ram_ext  = $signed({{(PW-DATAWIDTH){ram_data[DATAWIDTH-1]}}, ram_data});
    assign w_coef_ext = $signed({{(PW-COEFWIDTH){1'b0}}, coef_data});
    assign w_prod     = w_ram_ext * w_coef_ext;

    // S2: add one half LSB, then drop the fraction bits (slice == arithmetic shift).
    assign w_rnd_sum = $signed({r_p2[PW-1], r_p2}) + $signed(L_HALF);
    assign w_q       = $signed(w_rnd_sum[RW-1:COEFWIDTH]);

    always_comb begin
        w_sat = w_q[DATAWIDTH-1:0];
        if (w_q > L_MAX) begin
            w_sat = L_MAX[DATAWIDTH-1:0];
        end else if (w_q < L_MIN) begin
            w_sat = L_MIN[DATAWIDTH-1:0];
        end
    end

    // Credit accounting. A read with no free credit is a violation unless the
    // FIFO head leaves in the same cycle, which frees exactly the slot it needs.
    assign w_hs        = w_fifo_vld && m_ready;
    assign w_violation = read && (r_credits == L_FULL) && !w_hs;
    assign w_inc       = read && !w_violation;

    assign dequeue  = reset_n && (r_credits < L_FULL);
    assign overflow = r_overflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_credits  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({w_inc, w_hs})
                2'b10:   r_credits <= r_credits + L_CRED_ONE;
                2'b01:   r_credits <= r_credits - L_CRED_ONE;
                default: r_credits <= r_credits;
            endcase
            if (w_violation) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_p2    <= '0;
        end else begin
            r_v1    <= read;
            r_last1 <= read && (window_addr == {ADDRWIDTH{1'b1}});
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            r_p2    <= w_prod;
        end
    end

    wm_fifo #(
        .WIDTH (DATAWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_push_vld (r_v2),
        .i_push_dat ({r_last2, w_sat}),
        .i_pop_rdy  (m_ready),
        .o_pop_vld  (w_fifo_vld),
        .o_pop_dat  (w_fifo_head),
        .o_full     (w_fifo_full)
    );

    assign m_valid = w_fifo_vld;
    assign m_last  = w_fifo_head[DATAWIDTH];
    assign m_data  = w_fifo_head[DATAWIDTH-1:0];

    // Fullness is fully covered by the credit counter; the flag only exists for the drop path.
    logic w_unused;
    assign w_unused = w_fifo_full;
endmodule

// File: tb/tb_window_multiplier.sv
module tb_window_multiplier;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        dequeue;
    logic        read;
    logic [11:0] window_addr;
    logic [15:0] ram_data;
    logic [11:0] coef_addr;
    logic [15:0] coef_data;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] pend_d = '0;
    logic [15:0] pend_c = '0;

    window_multiplier #(
        .ADDRWIDTH (12),
        .DATAWIDTH (16),
        .COEFWIDTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dequeue    (dequeue),
        .read       (read),
        .window_addr(window_addr),
        .ram_data   (ram_data),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Reference: round(d*c / 2^16) with ties toward +inf, saturated to 16-bit signed.
    function automatic logic [15:0] wmul(input logic [15:0] d, input logic [15:0] c);
        longint p;
        p = longint'($signed(d)) * longint'(c);
        p = (p + 64'sd32768) >>> 16;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    // One clock cycle: drive read/address now, present last cycle's read data,
    // then return 1ns after the rising edge that closes the cycle.
    task automatic tick(input logic rd, input logic [11:0] addr,
                        input logic [15:0] d, input logic [15:0] c);
        read        = rd;
        window_addr = addr;
        ram_data    = pend_d;
        coef_data   = pend_c;
        pend_d      = d;
        pend_c      = c;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 12'd0, 16'd0, 16'd0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL reset_dequeue got %b want 0", dequeue); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data got %h want 0000", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (dequeue !== 1'b1) begin errors++; $display("FAIL release_dequeue got %b want 1", dequeue); end
    endtask

    task automatic test_single;
        m_ready = 1'b0;
        tick(1'b1, 12'd5, 16'h4000, 16'h8000);
        checks++; if (coef_addr !== 12'd5) begin errors++; $display("FAIL single_coef_addr got %0d want 5", coef_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_n1 got %b want 0", m_valid); end
        idle(1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_n2 got %b want 0", m_valid); end
        idle(1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_n3 got %b want 1", m_valid); end
        checks++; if (m_data !== 16'h2000) begin errors++; $display("FAIL single_data got %h want 2000", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL single_last got %b want 0", m_last); end
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", m_valid); end
    endtask

    task automatic test_rounding;
        logic [15:0] din [3]  = '{16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] cin [3]  = '{16'h8000, 16'hFFFF, 16'hFFFF};
        logic [15:0] dexp [3] = '{16'h0000, 16'h7FFF, 16'h8001};
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, 12'(10 + k), din[k], cin[k]);
        idle(2);
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== dexp[k]) begin
                errors++; $display("FAIL round_%0d got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, dexp[k]);
            end
            idle(1);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_last;
        logic [11:0] ain [3]  = '{12'd4094, 12'd4095, 12'd0};
        logic [15:0] dexp [3] = '{16'h0080, 16'h0100, 16'h0180};
        logic        lexp [3] = '{1'b0, 1'b1, 1'b0};
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, ain[k], 16'(32'h100 * (k + 1)), 16'h8000);
        idle(3);
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== dexp[k] || m_last !== lexp[k]) begin
                errors++; $display("FAIL last_%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                   k, m_valid, m_data, m_last, dexp[k], lexp[k]);
            end
            idle(1);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int   acc = 0;
        logic g;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            g = dequeue;
            tick(g, 12'(20 + i), 16'(32'h400 * (acc + 1)), 16'h8000);
            if (g) acc++;
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL bp_dequeue_low got %b want 0", dequeue); end
        m_ready = 1'b1;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin errors++; $display("FAIL bp_head got v=%b d=%h want v=1 d=0200", m_valid, m_data); end
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL bp_dequeue_before_pop got %b want 0", dequeue); end
        idle(1);
        checks++; if (dequeue !== 1'b1) begin errors++; $display("FAIL bp_dequeue_after_pop got %b want 1", dequeue); end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(32'h200 * (k + 1))) begin
                errors++; $display("FAIL bp_out_%0d got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, 16'(32'h200 * (k + 1)));
            end
            idle(1);
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", m_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b want 0", overflow); end
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back_random;
        logic [16:0] exp_q [$];
        logic [16:0] e;
        logic [11:0] a = 12'd4090;
        logic [15:0] d;
        logic [15:0] c;
        logic        rd;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < 100 && cyc < 3000) begin
            m_ready = ($urandom_range(0, 2) != 0);
            checks++;
            if (dequeue !== ((sent - got) < 4)) begin
                errors++; $display("FAIL rnd_dequeue cyc %0d got %b outstanding %0d", cyc, dequeue, sent - got);
            end
            if (m_valid === 1'b1 && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc %0d got d=%h with nothing expected", cyc, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++; $display("FAIL rnd_data #%0d got l=%b d=%h want l=%b d=%h", got, m_last, m_data, e[16], e[15:0]);
                    end
                end
                got++;
            end
            rd = dequeue && (sent < 100) && ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            c  = 16'($urandom);
            if (rd) begin
                exp_q.push_back({a == 12'd4095, wmul(d, c)});
                sent++;
            end
            tick(rd, a, d, c);
            if (rd) a = a + 12'd1;
            cyc++;
        end
        checks++; if (got != 100) begin errors++; $display("FAIL rnd_timeout got %0d outputs want 100", got); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_overflow got %b want 0", overflow); end
        m_ready = 1'b0;
        idle(1);
    endtask

    task automatic test_overflow;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick(1'b1, 12'(30 + k), 16'(32'h100 * (k + 1)), 16'h8000);
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL ovf_dequeue got %b want 0", dequeue); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        tick(1'b1, 12'd40, 16'h7000, 16'h8000);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        idle(3);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(32'h80 * (k + 1))) begin
                errors++; $display("FAIL ovf_out_%0d got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, 16'(32'h80 * (k + 1)));
            end
            idle(1);
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got v=%b d=%h want v=0", m_valid, m_data); end
        checks++; if (dequeue !== 1'b1) begin errors++; $display("FAIL ovf_credits_back got %b want 1", dequeue); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_clears_overflow got %b want 0", overflow); end
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, 12'(50 + k), 16'h1234, 16'h8000);
        idle(3);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rst_queued got %b want 1", m_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", m_valid); end
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL rst_async_dequeue got %b want 0", dequeue); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL rst_async_data got %h want 0000", m_data); end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (dequeue !== 1'b1) begin errors++; $display("FAIL rst_release_dequeue got %b want 1", dequeue); end
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m_valid === 1'b1) seen++;
            idle(1);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale got %0d outputs want 0", seen); end
        m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        read        = 1'b0;
        window_addr = '0;
        ram_data    = '0;
        coef_data   = '0;
        m_ready     = 1'b0;
        test_reset();
        test_single();
        test_rounding();
        test_last();
        test_backpressure();
        test_back_to_back_random();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
